// File: rtl/boreal_ledger.sv
// boreal_ledger: append-only hash-chained audit log with FWFT readout queue.
// Optional BOREAL_LEDGER_SEAL_EN adds a sticky seal that freezes the chain.
module boreal_ledger #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ledger_wr_en,
    input  logic [31:0]   led_opcode,
    input  logic [31:0]   led_nonce,
    input  logic [31:0]   led_policy_hash,
    input  logic          led_committed,
    output logic          led_ready,
    input  logic          rd_req,
    output logic          rd_valid,
    output logic [31:0]   rd_opcode,
    output logic [31:0]   rd_nonce,
    output logic          rd_committed,
    output logic [31:0]   rd_seq,
    output logic [31:0]   rd_chain,
    output logic [31:0]   head_hash,
    output logic [31:0]   seq_num,
    output logic [CW-1:0] entry_count,
    output logic          overflow,
    output logic          err_busy,
    input  logic          seal,
    output logic          sealed
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HASH, S_STORE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     op_q, op_d, nonce_q, nonce_d, pol_q, pol_d;
    logic            com_q, com_d;
    logic [31:0]     head_q, head_d, seq_q, seq_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d, err_busy_q, err_busy_d;
    logic [128:0]    mem_q [DEPTH];
    logic [128:0]    wr_word, rd_word;
    logic [31:0]     mix, h_new;
    logic            sealed_w, seal_now, accept, full, do_wr, do_pop;

`ifdef BOREAL_LEDGER_SEAL_EN
    logic sealed_q, sealed_d;
    assign seal_now = (state_q == S_IDLE) && seal;
    // Seal is sticky until reset
    always_comb sealed_d = sealed_q | seal_now;
    // Seal register
    always_ff @(posedge clk) sealed_q <= !rst_n ? 1'b0 : sealed_d;
    assign sealed_w = sealed_q;
`else
    logic seal_unused;
    assign seal_unused = seal;
    assign seal_now    = 1'b0;
    assign sealed_w    = 1'b0;
`endif

    assign led_ready = (state_q == S_IDLE) && !sealed_w;
    assign accept    = led_ready && ledger_wr_en && !seal_now;
    assign full      = count_q == CW'(DEPTH);
    assign rd_valid  = count_q != '0;
    assign do_wr     = (state_q == S_STORE) && !full;
    assign do_pop    = rd_req && rd_valid;
    assign mix       = head_q ^ op_q;
    assign h_new     = {mix[26:0], mix[31:27]} + (nonce_q ^ pol_q) + {31'b0, com_q} + seq_q;
    // In S_STORE head_q already holds h' and seq_q is one past the record's sequence
    assign wr_word   = {op_q, nonce_q, com_q, seq_q - 32'd1, head_q};
    assign rd_word   = rd_valid ? mem_q[rd_ptr_q] : '0;

    // Next-state, record latch, chain update and queue bookkeeping
    always_comb begin
        state_d    = accept ? S_HASH : state_q == S_HASH ? S_STORE : state_q == S_STORE ? S_IDLE : state_q;
        op_d       = accept ? led_opcode : op_q;
        nonce_d    = accept ? led_nonce : nonce_q;
        pol_d      = accept ? led_policy_hash : pol_q;
        com_d      = accept ? led_committed : com_q;
        head_d     = state_q == S_HASH ? h_new : head_q;
        seq_d      = state_q == S_HASH ? seq_q + 32'd1 : seq_q;
        wr_ptr_d   = wr_ptr_q + AW'(do_wr);
        rd_ptr_d   = rd_ptr_q + AW'(do_pop);
        count_d    = count_q + CW'(do_wr) - CW'(do_pop);
        overflow_d = overflow_q | ((state_q == S_STORE) && full);
        err_busy_d = err_busy_q | (ledger_wr_en && !led_ready);
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            nonce_q    <= '0;
            pol_q      <= '0;
            com_q      <= 1'b0;
            head_q     <= 32'h6A09E667;
            seq_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            nonce_q    <= nonce_d;
            pol_q      <= pol_d;
            com_q      <= com_d;
            head_q     <= head_d;
            seq_q      <= seq_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_busy_q <= err_busy_d;
        end
    end

    // Queue storage; contents are unreachable after reset since pointers clear
    always_ff @(posedge clk) begin
        if (rst_n && do_wr) mem_q[wr_ptr_q] <= wr_word;
    end

    assign rd_opcode    = rd_word[128:97];
    assign rd_nonce     = rd_word[96:65];
    assign rd_committed = rd_word[64];
    assign rd_seq       = rd_word[63:32];
    assign rd_chain     = rd_word[31:0];
    assign head_hash    = head_q;
    assign seq_num      = seq_q;
    assign entry_count  = count_q;
    assign overflow     = overflow_q;
    assign err_busy     = err_busy_q;
    assign sealed       = sealed_w;
endmodule

// File: tb/tb_boreal_ledger.sv
// tb_boreal_ledger: table, directed and randomized checks against a queue-based model.
module tb_boreal_ledger;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ledger_wr_en = 1'b0;
    logic [31:0]   led_opcode = '0, led_nonce = '0, led_policy_hash = '0;
    logic          led_committed = 1'b0;
    logic          led_ready;
    logic          rd_req = 1'b0;
    logic          rd_valid;
    logic [31:0]   rd_opcode, rd_nonce, rd_seq, rd_chain, head_hash, seq_num;
    logic          rd_committed;
    logic [CW-1:0] entry_count;
    logic          overflow, err_busy, sealed;
    logic          seal = 1'b0;

    boreal_ledger #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ledger_wr_en(ledger_wr_en),
        .led_opcode(led_opcode), .led_nonce(led_nonce), .led_policy_hash(led_policy_hash),
        .led_committed(led_committed), .led_ready(led_ready), .rd_req(rd_req),
        .rd_valid(rd_valid), .rd_opcode(rd_opcode), .rd_nonce(rd_nonce),
        .rd_committed(rd_committed), .rd_seq(rd_seq), .rd_chain(rd_chain),
        .head_hash(head_hash), .seq_num(seq_num), .entry_count(entry_count),
        .overflow(overflow), .err_busy(err_busy), .seal(seal), .sealed(sealed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic [31:0] nonce;
        logic        com;
        logic [31:0] seq;
        logic [31:0] chain;
    } rec_t;

    typedef struct {
        logic [31:0] op;
        logic [31:0] nonce;
        logic [31:0] pol;
        logic        com;
        logic [31:0] exp_head;
        logic        head_known;
    } vec_t;

    rec_t        mq[$];
    logic [31:0] m_head, m_seq;
    logic        m_over, m_err;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] next_hash(logic [31:0] h, logic [31:0] op, logic [31:0] n,
                                              logic [31:0] p, logic c, logic [31:0] s);
        logic [31:0] x;
        x = h ^ op;
        return ((x << 5) | (x >> 27)) + (n ^ p) + (c ? 32'd1 : 32'd0) + s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_head = 32'h6A09E667;
        m_seq  = 0;
        m_over = 0;
        m_err  = 0;
        mq.delete();
    endtask

    task automatic do_reset();
        rst_n = 0; ledger_wr_en = 0; rd_req = 0; seal = 0;
        tick();
        tick();
        rst_n = 1;
        model_reset();
    endtask

    task automatic check_all(input string tag);
        rec_t f;
        f = mq.size() > 0 ? mq[0] : '{32'd0, 32'd0, 1'b0, 32'd0, 32'd0};
        chk({tag, ".head"}, head_hash, m_head);
        chk({tag, ".seq_num"}, seq_num, m_seq);
        chk({tag, ".count"}, 32'(entry_count), 32'(mq.size()));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_over));
        chk({tag, ".err_busy"}, 32'(err_busy), 32'(m_err));
        chk({tag, ".led_ready"}, 32'(led_ready), 32'd1);
        chk({tag, ".sealed"}, 32'(sealed), 32'd0);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(mq.size() > 0));
        chk({tag, ".rd_opcode"}, rd_opcode, f.op);
        chk({tag, ".rd_nonce"}, rd_nonce, f.nonce);
        chk({tag, ".rd_committed"}, 32'(rd_committed), 32'(f.com));
        chk({tag, ".rd_seq"}, rd_seq, f.seq);
        chk({tag, ".rd_chain"}, rd_chain, f.chain);
    endtask

    // popk: cycle offset of a concurrent pop (-1 none); offset 2 coincides with the store
    task automatic model_record(input logic [31:0] op, input logic [31:0] n, input logic [31:0] p,
                                input logic c, input int popk);
        rec_t r;
        int   pre;
        r = '{op, n, c, m_seq, next_hash(m_head, op, n, p, c, m_seq)};
        m_head = r.chain;
        m_seq  = m_seq + 1;
        if ((popk == 0 || popk == 1) && mq.size() > 0) void'(mq.pop_front());
        pre = mq.size();
        if (popk == 2 && pre > 0) void'(mq.pop_front());
        if (pre < DEPTH) mq.push_back(r);
        else m_over = 1;
    endtask

    task automatic send(input logic [31:0] op, input logic [31:0] n, input logic [31:0] p,
                        input logic c, input int popk, input int busyk);
        led_opcode = op; led_nonce = n; led_policy_hash = p; led_committed = c;
        ledger_wr_en = 1; rd_req = (popk == 0);
        tick();
        led_opcode = $urandom; led_nonce = $urandom;
        ledger_wr_en = (busyk == 1); rd_req = (popk == 1);
        tick();
        ledger_wr_en = (busyk == 2); rd_req = (popk == 2);
        tick();
        ledger_wr_en = 0; rd_req = 0;
        model_record(op, n, p, c, popk);
        if (busyk > 0) m_err = 1;
    endtask

    task automatic send_rand(input int popk, input int busyk);
        send($urandom, $urandom, $urandom, 1'($urandom), popk, busyk);
    endtask

    task automatic pop();
        rd_req = 1;
        tick();
        rd_req = 0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0, 32'h0, 32'h0, 1'b0, 32'h279999E9, 1'b1};
        vecs[1] = '{32'hDEADBEEF, 32'h12345678, 32'h0F0F0F0F, 1'b1, 32'h0, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[3] = '{32'h80000000, 32'h1, 32'h1, 1'b1, 32'h0, 1'b0};
        vecs[4] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0};
        vecs[5] = '{32'h00000001, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0};

        // Reset values and the reference record with cycle-accurate timing
        do_reset();
        check_all("reset");
        led_opcode = 1; led_nonce = 1; led_policy_hash = 0; led_committed = 1;
        ledger_wr_en = 1;
        tick();
        ledger_wr_en = 0;
        chk("t1.led_ready", 32'(led_ready), 32'd0);
        chk("t1.head", head_hash, 32'h6A09E667);
        chk("t1.seq_num", seq_num, 32'd0);
        tick();
        chk("t2.head", head_hash, 32'h413CCCCF);
        chk("t2.seq_num", seq_num, 32'd1);
        chk("t2.led_ready", 32'(led_ready), 32'd0);
        chk("t2.rd_valid", 32'(rd_valid), 32'd0);
        tick();
        chk("t3.rd_valid", 32'(rd_valid), 32'd1);
        chk("t3.rd_seq", rd_seq, 32'd0);
        chk("t3.rd_chain", rd_chain, 32'h413CCCCF);
        chk("t3.led_ready", 32'(led_ready), 32'd1);
        model_record(1, 1, 0, 1, -1);
        check_all("first");

        // Table of records, then drain in order
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].op, vecs[i].nonce, vecs[i].pol, vecs[i].com, -1, 0);
            if (vecs[i].head_known) chk("vec.head_const", head_hash, vecs[i].exp_head);
            check_all($sformatf("vec%0d", i));
        end
        while (mq.size() > 0) begin
            pop();
            check_all("vec_drain");
        end

        // Strobe again while busy
        do_reset();
        send(32'h11, 32'h22, 32'h33, 1'b1, -1, 1);
        check_all("busy");

        // Overflow after DEPTH+1 records
        do_reset();
        for (int i = 0; i <= DEPTH; i++) send_rand(-1, 0);
        check_all("overflow");

        // Pop coinciding with a store into a full queue
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_rand(-1, 0);
        check_all("full");
        send_rand(2, 0);
        check_all("full_pop");

        // Pop coinciding with a store at count 3
        do_reset();
        for (int i = 0; i < 3; i++) send_rand(-1, 0);
        send_rand(2, 0);
        check_all("cnt3_pop");

        // Back-to-back drain of 5 entries plus 2 extra pops, then a wrapping refill
        do_reset();
        for (int i = 0; i < 5; i++) send_rand(-1, 0);
        rd_req = 1;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("drain%0d.rd_valid", i), 32'(rd_valid), 32'(i < 5));
            chk($sformatf("drain%0d.rd_seq", i), rd_seq, i < 5 ? 32'(i) : 32'd0);
            tick();
        end
        rd_req = 0;
        mq.delete();
        check_all("drained");
        seal = 1;
        send_rand(-1, 0);
        seal = 0;
        check_all("seal_ignored");
        for (int i = 1; i < DEPTH; i++) send_rand(-1, 0);
        check_all("refill");
        while (mq.size() > 0) begin
            pop();
            check_all("wrap_drain");
        end

        // Randomized traffic against the model
        do_reset();
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                pop();
            end else begin
                send_rand(int'($urandom_range(0, 3)) - 1,
                          $urandom_range(0, 9) == 0 ? int'($urandom_range(1, 2)) : 0);
            end
            check_all($sformatf("rand%0d", it));
        end

        // Reset mid-operation discards everything
        ledger_wr_en = 1;
        tick();
        ledger_wr_en = 0;
        do_reset();
        check_all("reset_mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
